// File: rtl/acquire_window_ctrl_pkg.sv
// Shared definitions for the acquisition window controller: FSM state
// encoding and the default UART command characters.
package acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } acq_state_e;

    localparam logic [7:0] CHAR_W = 8'h77;  // 'w' selects channel 0
    localparam logic [7:0] CHAR_I = 8'h69;  // 'i' selects channel 1
    localparam logic [7:0] CHAR_X = 8'h78;  // 'x' aborts an open window

    // Counter width able to hold 0..win without wrapping.
    function automatic int cnt_width(input int win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/acquire_window_ctrl_if.sv
// Bundle of the character input, waveform number and window status outputs.
// Handshake: char is only meaningful in a cycle where new_char=1; new_char is
// a single-cycle strobe with no back-pressure, and every character strobed
// is consumed in that same cycle (the controller has no ready signal).
interface acq_if
    import acq_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WAVE_W = 16
) ();
    logic [7:0]        char;
    logic              new_char;
    logic [WAVE_W-1:0] wavenum;
    logic [NUM_CH-1:0] acquire_n;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              cmd_err;
    acq_state_e        state_dbg;

    // Drives characters and waveform number, observes status.
    modport master (
        output char, new_char, wavenum,
        input  acquire_n, busy, done, timeout, cmd_err, state_dbg
    );

    // The controller side.
    modport slave (
        input  char, new_char, wavenum,
        output acquire_n, busy, done, timeout, cmd_err, state_dbg
    );
endinterface

// File: rtl/acquire_window_ctrl_cmd_decode.sv
// Combinational character decoder: reports whether char is a channel
// command (one-hot channel, lowest index wins on duplicates) and whether
// it is the abort character.
module acq_cmd_decode
    import acq_pkg::*;
#(
    parameter int                  NUM_CH     = 2,
    parameter logic [NUM_CH*8-1:0] CMD_CHARS  = {CHAR_I, CHAR_W},
    parameter logic [7:0]          ABORT_CHAR = CHAR_X
) (
    input  logic [7:0]        char_in,
    output logic              cmd_valid,
    output logic [NUM_CH-1:0] cmd_onehot,
    output logic              cmd_abort
);

    // Scan from the top channel down so the lowest matching channel is the
    // last one written and therefore wins.
    always_comb begin
        cmd_valid  = 1'b0;
        cmd_onehot = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (char_in == CMD_CHARS[k*8 +: 8]) begin
                cmd_valid     = 1'b1;
                cmd_onehot    = '0;
                cmd_onehot[k] = 1'b1;
            end
        end
    end

    assign cmd_abort = (char_in == ABORT_CHAR);

endmodule

// File: rtl/acquire_window_ctrl.sv
// Acquisition window controller. A command character opens a window of
// WIN_CYCLES cycles on one channel; the first waveform number change inside
// the window pulls that channel's acquire_n low until the window closes.
// The window ends with done (acquired) or timeout (nothing acquired); the
// abort character closes it early with no pulse.
module acquire_window_ctrl
    import acq_pkg::*;
#(
    parameter int                  NUM_CH     = 2,
    parameter int                  WIN_CYCLES = 36049,
    parameter int                  WAVE_W     = 16,
    parameter logic [NUM_CH*8-1:0] CMD_CHARS  = {CHAR_I, CHAR_W},
    parameter logic [7:0]          ABORT_CHAR = CHAR_X
) (
    input  logic  clk,
    input  logic  rst_n,
    acq_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_CYCLES - 1);

    acq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [WAVE_W-1:0] last_wave_q, last_wave_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic [NUM_CH-1:0] acquire_n_q, acquire_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              cmd_err_q, cmd_err_d;

    logic              cmd_valid;
    logic [NUM_CH-1:0] cmd_onehot;
    logic              cmd_abort;
    logic              win_end;

    acq_cmd_decode #(
        .NUM_CH     (NUM_CH),
        .CMD_CHARS  (CMD_CHARS),
        .ABORT_CHAR (ABORT_CHAR)
    ) u_decode (
        .char_in    (bus.char),
        .cmd_valid  (cmd_valid),
        .cmd_onehot (cmd_onehot),
        .cmd_abort  (cmd_abort)
    );

    assign win_end = (counter_q == CNT_LAST);

    // Next-state logic: command acceptance, window timing, acquisition start,
    // window end (which outranks both abort and a wavenum change) and abort.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        last_wave_d = last_wave_q;
        ch_d        = ch_q;
        acquire_n_d = acquire_n_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        cmd_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (bus.new_char) begin
                    if (cmd_valid) begin
                        ch_d    = cmd_onehot;
                        state_d = ST_ARMED;
                    end else if (!cmd_abort) begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_ARMED, ST_ACTIVE: begin
                if (win_end) begin
                    acquire_n_d = '1;
                    last_wave_d = bus.wavenum;
                    counter_d   = '0;
                    done_d      = (state_q == ST_ACTIVE);
                    timeout_d   = (state_q == ST_ARMED);
                    state_d     = ST_IDLE;
                end else if (bus.new_char && cmd_abort) begin
                    acquire_n_d = '1;
                    counter_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                    if (state_q == ST_ARMED && bus.wavenum != last_wave_q) begin
                        acquire_n_d = ~ch_q;
                        state_d     = ST_ACTIVE;
                    end
                end
            end
            default: begin
                acquire_n_d = '1;
                counter_d   = '0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset drops any open window silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            last_wave_q <= '0;
            ch_q        <= '0;
            acquire_n_q <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            last_wave_q <= last_wave_d;
            ch_q        <= ch_d;
            acquire_n_q <= acquire_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign bus.acquire_n = acquire_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.state_dbg = state_q;

endmodule
